// File: rtl/collatz_pkg.sv
// collatz_pkg: constants and types shared by the Collatz output-path blocks.
//   BITS         default width of each result word (multiple of 8)
//   HEADER       first byte of every result frame
//   FRAME_BYTES  header + three words + checksum, in bytes
//   state_t      framer FSM states
package collatz_pkg;

  localparam int unsigned BITS   = 32;
  localparam logic [7:0]  HEADER = 8'hC5;

  // Frame length for an arbitrary word width, so a framer built with a
  // different BITS override can still size its byte index correctly.
  function automatic int unsigned frame_bytes(input int unsigned bits);
    return 3 * bits / 8 + 2;
  endfunction

  localparam int unsigned FRAME_BYTES = frame_bytes(BITS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_CHECKSUM
  } state_t;

endpackage

// File: rtl/collatz_result_framer.sv
// collatz_result_framer: captures one finished Collatz result and emits it
// as a fixed-length checksummed byte frame:
//   HEADER, number (LSB first), orbit_len (LSB first),
//   path_record (LSB first), XOR of all preceding bytes.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   res_valid/ready   result handshake from the compute core
//   res_number        start value of the orbit
//   res_orbit_len     orbit length
//   res_path_record   highest value reached on the orbit
//   tx_data/valid     registered byte stream towards pins / UART
//   tx_ready          sink accepts tx_data
//   busy              frame in progress (inverse of res_ready)
//   frame_done        one-cycle pulse after the checksum byte is accepted
module collatz_result_framer
  import collatz_pkg::*;
#(
  parameter int unsigned BITS   = collatz_pkg::BITS,
  parameter logic [7:0]  HEADER = collatz_pkg::HEADER
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            res_valid,
  output logic            res_ready,
  input  logic [BITS-1:0] res_number,
  input  logic [BITS-1:0] res_orbit_len,
  input  logic [BITS-1:0] res_path_record,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic            busy,
  output logic            frame_done
);

  localparam int unsigned WORD_BYTES    = BITS / 8;
  localparam int unsigned PAYLOAD_BYTES = 3 * WORD_BYTES;
  localparam int unsigned IDX_W         = $clog2(frame_bytes(BITS));
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  sel_idx;
  logic [BITS-1:0]   num_q;
  logic [BITS-1:0]   orbit_q;
  logic [BITS-1:0]   path_q;
  logic [7:0]        csum;
  logic [7:0]        next_byte;
  logic              tx_fire;

  assign res_ready = (state == ST_IDLE);
  assign busy      = !res_ready;
  assign tx_fire   = tx_valid && tx_ready;

  // tx_data is registered, so the byte loaded on a handshake is the one
  // *after* the current index: payload byte 0 when leaving HEADER,
  // idx+1 while walking the payload.
  always_comb begin
    sel_idx = (state == ST_HEADER) ? '0 : IDX_W'(idx + 1'b1);
  end

  // word = index / WORD_BYTES, byte = index % WORD_BYTES
  always_comb begin
    next_byte = '0;
    for (int unsigned i = 0; i < PAYLOAD_BYTES; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        case (i / WORD_BYTES)
          0:       next_byte = num_q[8*(i % WORD_BYTES) +: 8];
          1:       next_byte = orbit_q[8*(i % WORD_BYTES) +: 8];
          default: next_byte = path_q[8*(i % WORD_BYTES) +: 8];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      num_q      <= '0;
      orbit_q    <= '0;
      path_q     <= '0;
      csum       <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (res_valid) begin
            num_q    <= res_number;
            orbit_q  <= res_orbit_len;
            path_q   <= res_path_record;
            csum     <= HEADER;
            tx_data  <= HEADER;
            tx_valid <= 1'b1;
            idx      <= '0;
            state    <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (tx_fire) begin
            tx_data <= next_byte;
            idx     <= '0;
            state   <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (tx_fire) begin
            csum <= csum ^ tx_data;
            if (idx == LAST_IDX) begin
              // Checksum byte must already include the last payload byte.
              tx_data <= csum ^ tx_data;
              state   <= ST_CHECKSUM;
            end else begin
              idx     <= IDX_W'(idx + 1'b1);
              tx_data <= next_byte;
            end
          end
        end
        ST_CHECKSUM: begin
          if (tx_fire) begin
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            frame_done <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/collatz_result_framer.md
# collatz_result_framer

Downstream stage of the Collatz compute core. It captures one finished result (start number, orbit length, path record) through a valid/ready handshake and emits it as a fixed-length, checksummed byte frame on an 8-bit valid/ready stream. That stream feeds the chip's dedicated output pins or a host-side UART.

## Interface

Parameters:
- BITS, 32: width of each result word; must be a multiple of 8.
- HEADER, 8'hC5: first byte of every frame.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- res_valid  in  1  compute core presents a finished result.
- res_ready  out  1  framer can accept a result; equals (state == IDLE).
- res_number  in  BITS  start value of the orbit.
- res_orbit_len  in  BITS  orbit length.
- res_path_record  in  BITS  highest value reached on the orbit.
- tx_data  out  8  current frame byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  sink accepts tx_data.
- busy  out  1  equals !res_ready.
- frame_done  out  1  one-cycle pulse after the checksum byte is accepted.

## Operation

- Frame layout, 3*BITS/8+2 bytes (14 at BITS=32), in order:
  - HEADER
  - res_number, LSB first
  - res_orbit_len, LSB first
  - res_path_record, LSB first
  - checksum: XOR of all preceding bytes, HEADER included.
- Capture: on a clock edge with res_valid && res_ready, latch all three words into internal registers. Inputs are don't-care afterwards.
- FSM states:
  - IDLE: go to HEADER on capture.
  - HEADER: go to PAYLOAD on tx handshake.
  - PAYLOAD: byte index 0..3*BITS/8-1; go to CHECKSUM on the handshake of the last index.
  - CHECKSUM: go to IDLE on handshake.
- Byte advance happens only on an edge with tx_valid && tx_ready.
- Checksum accumulator:
  - Initialised to HEADER at capture.
  - XORed with each accepted PAYLOAD byte.
  - Emitted unchanged in CHECKSUM.
- Payload byte select: word = index / (BITS/8); byte = index % (BITS/8).
- res_valid while busy is ignored; the result stays pending at the core and no data is lost.
- tx_ready while tx_valid = 0 is ignored.

## Timing

- Reset values:
  - state IDLE
  - res_ready 1, busy 0
  - tx_valid 0, tx_data 8'h00
  - frame_done 0
  - checksum and capture registers 0
- tx_data and tx_valid are registered. tx_data must hold stable while tx_valid && !tx_ready; the sink may stall indefinitely.
- Latency:
  - Capture at edge E0 puts the header on tx_data with tx_valid = 1 in the cycle after E0.
  - With tx_ready held high, the 14 handshakes fall at edges E1..E14.
  - After E14: tx_valid = 0, frame_done = 1 for one cycle, res_ready = 1.
  - The next capture is possible at E15, so one frame takes 15 cycles minimum.
- res_ready is combinational from the state, so the core may complete its handshake in the very cycle the framer returns to IDLE.
- Reset mid-frame:
  - Frame is abandoned and returns to IDLE next cycle.
  - tx_valid drops and no frame_done is produced.
  - The partial frame is not resumed.
- Reset has priority over any simultaneous handshake.

## Structure

- Shared package collatz_pkg holds:
  - BITS, HEADER
  - FRAME_BYTES = 3*BITS/8+2
  - state enum {IDLE, HEADER, PAYLOAD, CHECKSUM}
- The byte index counter width is derived from FRAME_BYTES in the package.
- No sub-module: one FSM, one index counter, a capture register bank and an 8-bit XOR accumulator fit in one module.

## Test plan

- Reset, then idle: res_ready = 1, tx_valid = 0, tx_data = 00, frame_done = 0.
- Basic frame: number = 27, orbit_len = 111, path_record = 9232, tx_ready held 1.
  - Bytes: C5 1B 00 00 00 6F 00 00 00 10 24 00 00 85.
  - frame_done pulses once, 15 cycles after capture.
- Backpressure: same inputs, tx_ready toggled pseudo-randomly. Byte sequence identical, tx_data stable throughout every stall.
- Busy rejection: res_valid held high with changing data mid-frame. Only the first result is framed; the second is captured in the IDLE cycle and framed back-to-back with no gap beyond one idle cycle.
- Reset mid-frame: assert reset after the 6th byte. tx_valid = 0 the next cycle, no frame_done. A fresh frame for number = 1 (orbit_len = 0, path_record = 1) then gives checksum C5^01^01 = C5.
- All-ones: BITS = 32, all three words FFFFFFFF. Checksum = C5 ^ (FF XORed 12 times) = C5.
